// File: rtl/rx_pattern_checker.sv
// Receive-side pattern checker: finds the bit rotation that turns the incoming
// word stream into an incrementing counter, then counts mismatches once locked.
//
// state  | meaning
// SEARCH | stepping the rotation offset and looking for a run of +1 words
// LOCKED | comparing every word with a free-running expected counter
module rx_pattern_checker #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 32,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             clear_stats,
  output logic [7:0]       aligned_data,
  output logic             aligned_valid,
  output logic             locked,
  output logic [2:0]       slip_offset,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic             err_pulse
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [2:0]  k;
  logic [7:0]  prev;
  logic [7:0]  ref_q;
  logic [7:0]  expected;
  logic [7:0]  run;
  logic [7:0]  miss;
  logic        primed;
  logic        have_ref;

  logic [15:0] window;
  logic [7:0]  cand;
  logic        beat;
  logic        match_ref;
  logic        match_exp;
  logic        lock_hit;
  logic        unlock_hit;
  logic        err_hit;

  // The very first beat only loads prev, so a candidate exists from beat two on.
  assign beat       = rx_valid & primed;
  assign window     = {rx_data, prev};
  assign cand       = window[k +: 8];
  assign match_ref  = (cand == ref_q + 8'd1);
  assign match_exp  = (cand == expected);
  assign lock_hit   = (({1'b0, run} + 9'd1) == 9'(LOCK_CNT));
  assign unlock_hit = (({1'b0, miss} + 9'd1) == 9'(UNLOCK_CNT));
  assign slip_offset = k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEARCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (beat) begin
      case (state)
        SEARCH:  if (have_ref && match_ref && lock_hit) state_nxt = LOCKED;
        LOCKED:  if (!match_exp && unlock_hit)          state_nxt = SEARCH;
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked  = (state == LOCKED);
    err_hit = beat && (state == LOCKED) && !match_exp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aligned_data  <= 8'd0;
      aligned_valid <= 1'b0;
      err_pulse     <= 1'b0;
      k             <= 3'd0;
      prev          <= 8'd0;
      primed        <= 1'b0;
      ref_q         <= 8'd0;
      have_ref      <= 1'b0;
      run           <= 8'd0;
      miss          <= 8'd0;
      expected      <= 8'd0;
    end else begin
      aligned_valid <= beat;
      err_pulse     <= err_hit;
      if (beat) aligned_data <= cand;
      if (rx_valid) begin
        prev   <= rx_data;
        primed <= 1'b1;
      end
      if (beat) begin
        case (state)
          SEARCH: begin
            if (!have_ref) begin
              ref_q    <= cand;
              have_ref <= 1'b1;
            end else if (match_ref) begin
              run   <= run + 8'd1;
              ref_q <= cand;
              if (lock_hit) begin
                expected <= cand + 8'd1;
                miss     <= 8'd0;
              end
            end else begin
              run      <= 8'd0;
              have_ref <= 1'b0;
              k        <= k + 3'd1;
            end
          end
          LOCKED: begin
            // Never resynchronised from data: a slipped stream keeps failing.
            expected <= expected + 8'd1;
            if (match_exp) begin
              miss <= 8'd0;
            end else begin
              miss <= miss + 8'd1;
              if (unlock_hit) begin
                run      <= 8'd0;
                have_ref <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Clear has priority over a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count  <= '0;
      word_count <= '0;
    end else if (clear_stats) begin
      err_count  <= '0;
      word_count <= '0;
    end else begin
      if (err_hit && !(&err_count)) err_count <= err_count + 1'b1;
      if (beat && (state == LOCKED) && !(&word_count)) word_count <= word_count + 1'b1;
    end
  end

endmodule

// File: doc/rx_pattern_checker.md
Name: rx_pattern_checker

Overview:
- Sits directly downstream of the HPIO receive interface. It consumes the 8-bit parallel words that the receive path delivers to fabric.
- Finds the bit rotation at which the received stream forms an incrementing 8-bit counter, which is the pattern the transmit-side data generator produces.
- After locking, it checks every word against a free-running expected counter and keeps error and word statistics for debug-core probing.
- Gives the loopback test a pass/fail measure with no waveform inspection.

Parameters:
LOCK_CNT, 16, consecutive +1 matches required in SEARCH before declaring lock (range 2..255)
UNLOCK_CNT, 4, consecutive mismatches in LOCKED that force a return to SEARCH (range 1..255)
CNT_W, 32, width of word_count
ERR_W, 16, width of err_count

Ports:
clk  input  1  sole clock; every register is in this domain
rst  input  1  asynchronous, active-high reset
rx_data  input  8  received parallel word
rx_valid  input  1  rx_data is valid this cycle (a "beat"); gaps of any length are allowed
clear_stats  input  1  synchronous clear of err_count and word_count
aligned_data  output  8  rotation-corrected word
aligned_valid  output  1  aligned_data valid
locked  output  1  checker is in LOCKED state
slip_offset  output  3  current rotation offset k
err_count  output  ERR_W  mismatches seen while LOCKED, saturating
word_count  output  CNT_W  beats checked while LOCKED, saturating
err_pulse  output  1  one-cycle pulse per LOCKED mismatch

Behaviour:
- Reset values: all outputs 0. Internally: state=SEARCH, k=0, prev=0, primed=0, have_ref=0, run=0, miss=0, expected=0.
- Reset mid-operation drops locked and clears statistics immediately (asynchronous).
- Cycles with rx_valid=0 change no state. Outputs that pulse (aligned_valid, err_pulse) go 0 in those cycles.
- Window and candidate on each beat:
  - window = {rx_data, prev}, 16 bits.
  - cand = window[k+7:k].
  - After that, prev <= rx_data and primed <= 1.
  - The first beat after reset only primes prev. It produces no candidate and no aligned_valid.
- Output latency: aligned_data <= cand and aligned_valid <= 1 on the cycle after each primed beat. This applies in every state.
- SEARCH state, on each primed beat:
  - have_ref=0: ref <= cand, have_ref <= 1.
  - have_ref=1 and cand == ref+1 (mod 256): run <= run+1 and ref <= cand.
    - If run+1 == LOCK_CNT: state <= LOCKED, expected <= cand+1, miss <= 0, locked <= 1 on the next cycle.
  - have_ref=1 and mismatch: run <= 0, have_ref <= 0, k <= k+1 (wraps 7 -> 0).
- LOCKED state, on each primed beat:
  - word_count +1, saturating at all ones.
  - expected <= expected+1, free-running. It is never resynchronised from data.
  - cand == expected: miss <= 0.
  - cand != expected:
    - err_count +1, saturating at all ones.
    - err_pulse=1 on the next cycle.
    - miss <= miss+1.
    - If miss+1 == UNLOCK_CNT: state <= SEARCH, locked <= 0, run <= 0, have_ref <= 0. k is kept, so search resumes at the last good offset.
- slip_offset always reflects k.
- clear_stats (synchronous) zeroes err_count and word_count. If it coincides with an increment, the clear wins and the result is 0. It does not affect state, k, or locked.
- All additions on 8-bit data are modulo 256. The wrap 0xFF -> 0x00 counts as a valid increment.

Test Plan:
- Aligned counter: reset, then drive rx_data = 0x00, 0x01, ... on consecutive beats -> locked rises the cycle after the 18th beat; slip_offset=0; aligned_data tracks the counter one cycle late; err_count=0.
- Rotated stream: let S be the LSB-first bitstream of counter bytes; drive rx_data[t] = S[8t+3 +: 8] -> lock within 8*(LOCK_CNT+2) beats with slip_offset=5; err_count=0.
- Single error: while locked, XOR one word with 0x10 -> err_pulse exactly once, err_count=1, locked stays 1, following words match.
- Loss of lock: while locked, corrupt 4 consecutive words -> err_count=4, locked falls after the 4th corrupt beat, slip_offset unchanged; clean data relocks.
- Gaps and wrap: insert random rx_valid=0 gaps across the 0xFF -> 0x00 transition -> no errors, word_count equals the number of beats since lock.
- Clear/reset: pulse clear_stats in the same cycle as an error -> err_count=0. Assert rst mid-lock -> all outputs 0 immediately.
